// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer for the 16-bit CPU.
// Drives imem requests from the current PC, holds one fetched word for decode,
// and computes the next PC (written back every cycle) for sequential advance,
// branch redirect, decode stall and HLT.
// Optional build macro FETCH_TIMEOUT_EN adds a memory-response timeout that
// stops fetch and raises a sticky fetch_err.
module fetch_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_cur,
  output logic [15:0] pc_next,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic        halted,
  output logic        fetch_err
);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        halted_q, halted_d;

  logic accept;
  logic fire;
  logic is_hlt;
  logic redirect;
  logic timeout_hit;

  assign accept    = instr_valid_q & ~stall;
  assign imem_req  = (state_q == RUN) & ~rst & (~instr_valid_q | ~stall);
  assign fire      = imem_req & imem_ready & ~branch_taken;
  assign is_hlt    = (imem_data[15:12] == 4'hF);
  assign redirect  = branch_taken & (state_q != HALT);
  assign imem_addr = pc_cur;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       fetch_err_q, fetch_err_d;

  // Count cycles an outstanding request goes unanswered; expire at TIMEOUT_CYCLES.
  always_comb begin
    wait_cnt_d  = 8'd0;
    timeout_hit = 1'b0;
    if (imem_req & ~imem_ready & ~branch_taken) begin
      wait_cnt_d  = wait_cnt_q + 8'd1;
      timeout_hit = (wait_cnt_d == 8'(TIMEOUT_CYCLES));
    end
    fetch_err_d = fetch_err_q | timeout_hit;
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q  <= 8'd0;
      fetch_err_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  // Next-PC select: the PC register loads every cycle, so holding means pc_cur.
  always_comb begin
    pc_next = pc_cur;
    if (rst) begin
      pc_next = 16'h0000;
    end else if (redirect) begin
      pc_next = branch_target;
    end else if (fire & ~is_hlt) begin
      pc_next = pc_cur + 16'd2;
    end
  end

  // FSM next state and output-register update; HALT freezes everything.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    if (state_q != HALT) begin
      if (branch_taken) begin
        instr_valid_d = 1'b0;
        state_d       = RUN;
      end else if (timeout_hit) begin
        instr_valid_d = 1'b0;
        halted_d      = 1'b1;
        state_d       = HALT;
      end else if (fire) begin
        instr_d       = imem_data;
        instr_valid_d = 1'b1;
        if (is_hlt) begin
          state_d = DRAIN;
        end
      end else if (accept) begin
        instr_valid_d = 1'b0;
        if (state_q == DRAIN) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      instr_q       <= 16'h0000;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;

endmodule
